// File: rtl/fcpu_pkg.sv
// Shared fcpu definitions: CRAM window geometry, AXI ID width and AXI
// burst/response encodings used by the CRAM read responder.
package fcpu_pkg;

    localparam int CRAM_ADDR_W = 12;
    localparam int ID_WIDTH    = 4;
    localparam int BURST_W     = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/cram_bram.sv
// Simple dual-port CRAM storage: one enabled read port with a registered
// output and one write port. A same-cycle read of a written word returns the old data.
module cram_bram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Contents and output register are deliberately unreset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cram_axi_responder.sv
// AXI4 read-only responder for the CRAM window: one outstanding INCR burst,
// one beat per cycle, SLVERR for unsupported bursts and DECERR past the window.
module cram_axi_responder
    import fcpu_pkg::*;
#(
    parameter int ID_W   = ID_WIDTH,
    parameter int ADDR_W = CRAM_ADDR_W,
    parameter int LEN_W  = 8
) (
    input  logic               clk,
    input  logic               nrst,

    input  logic [ID_W-1:0]    cram_arid,
    input  logic [31:0]        cram_araddr,
    input  logic [LEN_W-1:0]   cram_arlen,
    input  logic [2:0]         cram_arsize,
    input  logic [BURST_W-1:0] cram_arburst,
    input  logic               cram_arlock,
    input  logic [3:0]         cram_arcache,
    input  logic [2:0]         cram_arprot,
    input  logic [3:0]         cram_arqos,
    input  logic               cram_arvalid,
    output logic               cram_arready,

    output logic [ID_W-1:0]    cram_rid,
    output logic [31:0]        cram_rdata,
    output logic [1:0]         cram_rresp,
    output logic               cram_rlast,
    output logic               cram_rvalid,
    input  logic               cram_rready,

    input  logic               ld_en,
    input  logic [ADDR_W-3:0]  ld_addr,
    input  logic [31:0]        ld_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DATA
    } state_t;

    state_t            state, state_nx;
    logic [32:0]       addr_q, addr_nx, addr_inc;
    logic [LEN_W-1:0]  cnt_q, cnt_nx;
    logic [ID_W-1:0]   id_q, id_nx;
    logic              slverr_q, slverr_nx;
    logic [1:0]        resp_q, resp_nx;
    logic              arready_q;

    logic              rd_en;
    logic [ADDR_W-3:0] rd_addr;
    logic [31:0]       bram_q;

    logic              last;
    logic              ar_hs;
    logic              r_hs;
    logic              unused_ar;

    assign unused_ar = ^{cram_arlock, cram_arcache, cram_arprot, cram_arqos};

    function automatic logic [1:0] beat_resp(input logic slv, input logic [32:0] a);
        if (slv) begin
            return RESP_SLVERR;
        end else if (|(a >> ADDR_W)) begin
            return RESP_DECERR;
        end
        return RESP_OKAY;
    endfunction

    assign addr_inc = addr_q + 33'd4;
    assign last     = (cnt_q == '0);
    assign ar_hs    = cram_arvalid && arready_q;
    assign r_hs     = (state == ST_DATA) && cram_rready;

    always_comb begin
        state_nx  = state;
        addr_nx   = addr_q;
        cnt_nx    = cnt_q;
        id_nx     = id_q;
        slverr_nx = slverr_q;
        resp_nx   = resp_q;
        rd_en     = 1'b0;
        rd_addr   = addr_q[ADDR_W-1:2];

        case (state)
            ST_IDLE: begin
                if (ar_hs) begin
                    id_nx     = cram_arid;
                    addr_nx   = {1'b0, cram_araddr};
                    cnt_nx    = cram_arlen;
                    slverr_nx = (cram_arburst != BURST_INCR) || (cram_arsize != 3'd2);
                    state_nx  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rd_en    = 1'b1;
                resp_nx  = beat_resp(slverr_q, addr_q);
                state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (r_hs) begin
                    if (last) begin
                        state_nx = ST_IDLE;
                    end else begin
                        // Prefetch the next word on the accepting edge so beats stay back-to-back.
                        addr_nx = addr_inc;
                        cnt_nx  = cnt_q - LEN_W'(1);
                        rd_en   = 1'b1;
                        rd_addr = addr_inc[ADDR_W-1:2];
                        resp_nx = beat_resp(slverr_q, addr_inc);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            arready_q <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            id_q      <= '0;
            slverr_q  <= 1'b0;
            resp_q    <= RESP_OKAY;
        end else begin
            state     <= state_nx;
            arready_q <= (state_nx == ST_IDLE);
            addr_q    <= addr_nx;
            cnt_q     <= cnt_nx;
            id_q      <= id_nx;
            slverr_q  <= slverr_nx;
            resp_q    <= resp_nx;
        end
    end

    cram_bram #(
        .AW (ADDR_W - 2),
        .DW (32)
    ) u_bram (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (bram_q),
        .wr_en   (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data)
    );

    // The BRAM output register only loads on rd_en, so it already holds
    // during stalls; error beats and reset just mask it to zero.
    assign cram_arready = arready_q;
    assign cram_rvalid  = (state == ST_DATA);
    assign cram_rid     = id_q;
    assign cram_rresp   = cram_rvalid ? resp_q : RESP_OKAY;
    assign cram_rlast   = cram_rvalid && last;
    assign cram_rdata   = (cram_rvalid && resp_q == RESP_OKAY) ? bram_q : '0;

endmodule

// File: doc/cram_axi_responder.md
CRAM_AXI_RESPONDER -- requirements
Module: cram_axi_responder

Interface
REQ-001 SHALL have parameter ID_W, default ID_WIDTH, AXI ID width.
REQ-002 SHALL have parameter ADDR_W, default CRAM_ADDR_W, byte-address width of the CRAM window; depth = 2**(ADDR_W-2) words.
REQ-003 SHALL have parameter LEN_W, default 8, burst length field width.
REQ-004 clk  in  1  single clock; all state rises on posedge clk.
REQ-005 nrst  in  1  asynchronous active-low reset.
REQ-006 cram_arid/araddr/arlen/arsize/arburst  in  ID_W/32/LEN_W/3/2  AR channel payload; arlock/arcache/arprot/arqos inputs are accepted and ignored.
REQ-007 cram_arvalid  in  1 / cram_arready  out  1  AR handshake.
REQ-008 cram_rid/rdata/rresp/rlast  out  ID_W/32/2/1  R channel payload.
REQ-009 cram_rvalid  out  1 / cram_rready  in  1  R handshake.
REQ-010 ld_en  in  1, ld_addr  in  ADDR_W-2, ld_data  in  32: word write port for program loading.

Function
REQ-011 SHALL implement an AXI4 read-only responder with one outstanding burst.
REQ-012 States SHALL be IDLE, FETCH, DATA; reset state IDLE.
REQ-013 IDLE: arready=1, rvalid=0; on arvalid&arready, latch id, araddr, beat count=arlen, error flags -> FETCH.
REQ-014 FETCH: arready=0, rvalid=0; memory read of current word issued -> DATA next cycle.
REQ-015 DATA: rvalid=1; rdata, rresp, rlast, rid SHALL hold stable until rready.
REQ-016 On DATA handshake with rlast=0: address += 4, count -= 1, next word read in the same cycle, rvalid stays 1 next cycle (no bubble).
REQ-017 On DATA handshake with rlast=1 -> IDLE; arready asserts the following cycle.
REQ-018 rlast SHALL equal (count == 0) in DATA.
REQ-019 Latency: AR accepted at cycle N -> first rvalid at N+2; one beat per cycle thereafter under rready=1.
REQ-020 Word index = address[ADDR_W-1:2]; address[1:0] ignored; address incremented in 33-bit arithmetic (no wrap).
REQ-021 Beats with address >= 2**ADDR_W SHALL return rresp=DECERR (2'b11), rdata=0; other beats of the burst unaffected.
REQ-022 arburst != INCR or arsize != 2 SHALL return SLVERR (2'b10), rdata=0, on all arlen+1 beats.
REQ-023 Normal beats SHALL return rresp=OKAY (2'b00).
REQ-024 ld_en write SHALL take effect at posedge; simultaneous ld write and read of same word SHALL return old data (read-first).
REQ-025 ld writes SHALL be accepted in any state.
REQ-026 rdata register SHALL not change while rvalid=1 and rready=0.

Reset
REQ-027 nrst low SHALL asynchronously force state IDLE, arready=0 during reset then 1 in IDLE, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, count=0.
REQ-028 Reset mid-burst SHALL abandon the burst; no further beats after release.
REQ-029 CRAM contents SHALL not be cleared by reset.

Structure
REQ-030 CRAM_ADDR_W, ID_WIDTH, BURST_W and rresp encodings (RESP_OKAY, RESP_SLVERR, RESP_DECERR) and burst encoding BURST_INCR SHALL live in fcpu_pkg.
REQ-031 State enum SHALL be local to the module.
REQ-032 Storage SHALL be one sub-module cram_bram: one read port with enable and 1-cycle registered output, one write port, read-first.

Verification
REQ-033 Preload words 0..3 = 0x11,0x22,0x33,0x44; AR addr 0x0, len 3, size 2, INCR, rready=1 -> rvalid at N+2, rdata 0x11,0x22,0x33,0x44 on consecutive cycles, OKAY, rlast on 4th beat only.
REQ-034 Same burst with rready toggling 1,0,0,1,... -> each beat held stable while stalled; order and rlast unchanged; no extra beats.
REQ-035 AR addr 2**ADDR_W-8, len 3 -> beats 0,1 OKAY with stored data; beats 2,3 DECERR, rdata 0.
REQ-036 AR arburst=FIXED, len 1 -> two beats SLVERR, rdata 0, rlast on 2nd; arid echoed on rid.
REQ-037 nrst pulsed low during beat 2 of a len-7 burst -> rvalid falls immediately, IDLE after release, next burst correct from beat 0.
REQ-038 ld_en write 0xDEAD to word 5 in the cycle word 5 is read -> old value returned; subsequent burst returns 0xDEAD.
